alaw_serial_rx: RTL

//  Receive end of the serial A-law PCM link: deserialises one 8-bit A-law timeslot per frame from sdata.

---
 rtl/alaw_pkg.sv | 32 +++
 rtl/alaw_rx_fifo.sv | 61 ++++++
 rtl/alaw_serial_rx.sv | 136 +++++++++++++
 3 files changed

// File: rtl/alaw_pkg.sv
// Shared A-law constants, receiver FSM states and the G.711 A-law to linear expansion.
// Used by alaw_serial_rx (optional dropped-sample counter: ALAW_RX_OVF_CNT_EN) and encoder bench models.
package alaw_pkg;

    localparam logic [7:0] ALAW_XOR_MASK = 8'h55;
    localparam int         ALAW_LIN_W    = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } rx_state_t;

    // Segment 0 is linear with a half-step offset; higher segments carry the implied leading one.
    function automatic logic [ALAW_LIN_W-1:0] alaw_expand(input logic [7:0] code);
        logic [7:0]            x;
        logic [2:0]            seg;
        logic [3:0]            man;
        logic [ALAW_LIN_W-1:0] mag;
        x   = code ^ ALAW_XOR_MASK;
        seg = x[6:4];
        man = x[3:0];
        if (seg == 3'd0) begin
            mag = {8'd0, man, 4'b1000};
        end else begin
            mag = ({8'd0, man, 4'b0000} + 16'h0108) << (seg - 3'd1);
        end
        return x[7] ? mag : (~mag + 16'd1);
    endfunction

endpackage

// File: rtl/alaw_rx_fifo.sv
// Synchronous FIFO for decoded samples; a separate occupancy count tells full from empty.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module alaw_rx_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (do_push && !do_pop) begin
                cnt <= cnt + CW'(1);
            end else if (do_pop && !do_push) begin
                cnt <= cnt - CW'(1);
            end
        end
    end

    assign pop_data = mem[rd_ptr];
    assign full     = (cnt == CW'(DEPTH));
    assign empty    = (cnt == '0);
    assign count    = cnt;

endmodule

// File: rtl/alaw_serial_rx.sv
// Serial A-law timeslot receiver: frame FSM, shift register, decode register and sample FIFO.
// Define ALAW_RX_OVF_CNT_EN to add the saturating ovf_count dropped-sample counter port.
module alaw_serial_rx
    import alaw_pkg::*;
#(
    parameter int SLOT_INDEX = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  bit_en,
    input  logic                  fsync,
    input  logic                  sdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ALAW_LIN_W-1:0] out_data,
    output logic [7:0]            out_alaw,
    output logic                  out_ovf
`ifdef ALAW_RX_OVF_CNT_EN
    ,
    output logic [15:0]           ovf_count
`endif
);

    localparam logic [7:0] SLOT_FIRST = 8'(8 * SLOT_INDEX);
    localparam int         CW         = $clog2(FIFO_DEPTH + 1);

    rx_state_t             state, state_n;
    logic [7:0]            bitcnt, bitcnt_n;
    logic [7:0]            sreg;
    logic [7:0]            idx;
    logic [7:0]            slot_ofs;
    logic                  advance;
    logic                  shift_en;
    logic                  byte_done;
    logic                  dec_valid;
    logic [ALAW_LIN_W-1:0] dec_data;
    logic [7:0]            dec_alaw;
    logic [7:0]            byte_now;

    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CW-1:0]         fifo_count;
    logic [23:0]           fifo_rdata;

    // A qualified fsync always restarts the frame as bit 0, whatever state we were in.
    always_comb begin
        state_n   = state;
        bitcnt_n  = bitcnt;
        shift_en  = 1'b0;
        byte_done = 1'b0;
        advance   = 1'b0;
        idx       = fsync ? 8'd0 : bitcnt;
        slot_ofs  = idx - SLOT_FIRST;
        if (bit_en) begin
            case (state)
                ST_IDLE, ST_DONE:  advance = fsync;
                ST_COUNT, ST_SHIFT: advance = 1'b1;
                default:           advance = 1'b0;
            endcase
        end
        if (advance) begin
            bitcnt_n = idx + 8'd1;
            if (slot_ofs < 8'd8) begin
                shift_en = 1'b1;
            end
            if (slot_ofs == 8'd7) begin
                state_n   = ST_DONE;
                byte_done = 1'b1;
            end else if (slot_ofs < 8'd8) begin
                state_n = ST_SHIFT;
            end else begin
                state_n = ST_COUNT;
            end
        end
    end

    assign byte_now = {sreg[6:0], sdata};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            bitcnt    <= '0;
            sreg      <= '0;
            dec_valid <= 1'b0;
            dec_data  <= '0;
            dec_alaw  <= '0;
        end else begin
            state     <= state_n;
            bitcnt    <= bitcnt_n;
            dec_valid <= byte_done;
            if (shift_en) begin
                sreg <= byte_now;
            end
            if (byte_done) begin
                dec_alaw <= byte_now;
                dec_data <= alaw_expand(byte_now);
            end
        end
    end

    assign fifo_pop = out_ready && !fifo_empty;

    alaw_rx_fifo #(
        .WIDTH (24),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (dec_valid),
        .push_data ({dec_alaw, dec_data}),
        .pop       (fifo_pop),
        .pop_data  (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // No bypass: a sample only becomes visible once it sits in the FIFO.
    assign out_valid = (fifo_count != '0);
    assign out_alaw  = fifo_rdata[23:16];
    assign out_data  = fifo_rdata[15:0];
    assign out_ovf   = dec_valid && fifo_full && !out_ready;

`ifdef ALAW_RX_OVF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_count <= '0;
        end else if (out_ovf && (ovf_count != 16'hFFFF)) begin
            ovf_count <= ovf_count + 16'd1;
        end
    end
`endif

endmodule
